// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the bus, frames 11-bit packets, folds E0/F0 prefixes into flags.
// Latency: raw clock fall + 2 sync + FILTER_LEN filter cycles to the sample; code_valid/frame_err one cycle after the stop-bit sample.
// No backpressure: results are one-cycle pulses and the downstream decoder must accept every one.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KB_clk,
    input  logic       data,
    output logic [7:0] code,
    output logic       is_break,
    output logic       is_extended,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic                  kb_s1, kb_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  filt_clk;
    logic                  sample_evt;
    logic                  sample_bit;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par_bit, par_nxt;
    logic          ext, ext_nxt, brk, brk_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]    code_nxt;
    logic          is_break_nxt, is_extended_nxt, code_valid_nxt, frame_err_nxt;

    // Everything presets high so reset looks like an idle bus and never fakes a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kb_s1    <= 1'b1;
            kb_s2    <= 1'b1;
            d_s1     <= 1'b1;
            d_s2     <= 1'b1;
            filt     <= '1;
            filt_clk <= 1'b1;
        end else begin
            kb_s1 <= KB_clk;
            kb_s2 <= kb_s1;
            d_s1  <= data;
            d_s2  <= d_s1;
            filt  <= {filt[FILTER_LEN-2:0], kb_s2};
            if (filt == '0)
                filt_clk <= 1'b0;
            else if (filt == '1)
                filt_clk <= 1'b1;
        end
    end

    // The cycle in which the filtered level is about to drop is the sample cycle.
    assign sample_evt = filt_clk && (filt == '0);
    assign sample_bit = d_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            ext         <= 1'b0;
            brk         <= 1'b0;
            to_cnt      <= '0;
            code        <= '0;
            is_break    <= 1'b0;
            is_extended <= 1'b0;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            par_bit     <= par_nxt;
            ext         <= ext_nxt;
            brk         <= brk_nxt;
            to_cnt      <= to_cnt_nxt;
            code        <= code_nxt;
            is_break    <= is_break_nxt;
            is_extended <= is_extended_nxt;
            code_valid  <= code_valid_nxt;
            frame_err   <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift;
        par_nxt         = par_bit;
        ext_nxt         = ext;
        brk_nxt         = brk;
        to_cnt_nxt      = to_cnt;
        code_nxt        = code;
        is_break_nxt    = is_break;
        is_extended_nxt = is_extended;
        code_valid_nxt  = 1'b0;
        frame_err_nxt   = 1'b0;

        if (sample_evt) begin
            to_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (!sample_bit) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shift_nxt   = {sample_bit, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
                PARITY: begin
                    par_nxt   = sample_bit;
                    state_nxt = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (sample_bit && ((^shift) ^ par_bit)) begin
                        if (shift == 8'hE0) begin
                            ext_nxt = 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_nxt = 1'b1;
                        end else begin
                            code_nxt        = shift;
                            is_extended_nxt = ext;
                            is_break_nxt    = brk;
                            code_valid_nxt  = 1'b1;
                            ext_nxt         = 1'b0;
                            brk_nxt         = 1'b0;
                        end
                    end else begin
                        frame_err_nxt = 1'b1;
                        ext_nxt       = 1'b0;
                        brk_nxt       = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_nxt     = IDLE;
                frame_err_nxt = 1'b1;
                ext_nxt       = 1'b0;
                brk_nxt       = 1'b0;
                to_cnt_nxt    = '0;
            end else begin
                to_cnt_nxt = to_cnt + 1'b1;
            end
        end
    end

endmodule
